// File: rtl/sprite_rom_pkg.sv
// Shared types and sizing for the sprite ROM arbiter: ROM geometry, requester vectors
// and the tag that travels alongside each read.
package sprite_rom_pkg;

  localparam int NUM_REQ   = 4;
  localparam int ADDR_W    = 19;
  localparam int DATA_W    = 4;
  localparam int ROM_DEPTH = 307200;
  localparam int ROM_LAT   = 2;
  localparam int PTR_W     = $clog2(NUM_REQ);

  typedef logic [ADDR_W-1:0]  rom_addr_t;
  typedef logic [NUM_REQ-1:0] req_vec_t;
  typedef logic [PTR_W-1:0]   ptr_t;

  typedef struct packed {
    logic     v;
    req_vec_t id;
    logic     oor;
  } rom_tag_t;

  // Unsigned compare at ADDR_W bits; ROM_DEPTH fits in ADDR_W.
  function automatic logic addr_oor(input rom_addr_t a);
    return a >= rom_addr_t'(ROM_DEPTH);
  endfunction

endpackage

// File: rtl/sprite_rom_arbiter_rr.sv
// Round-robin arbiter: grants the first request at or after the pointer,
// then moves the pointer one past the winner unless hold is asserted.
module rr_arbiter
  import sprite_rom_pkg::*;
(
  input  logic     vga_clk,
  input  logic     reset_n,
  input  req_vec_t req,
  input  logic     hold,
  output req_vec_t gnt
);

  ptr_t ptr;
  ptr_t ptr_nxt;
  logic found;

  always_comb begin
    gnt     = '0;
    ptr_nxt = ptr;
    found   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int i;
      i = (int'(ptr) + k) % NUM_REQ;
      if (!found && req[i]) begin
        found   = 1'b1;
        gnt[i]  = 1'b1;
        ptr_nxt = ptr_t'((i + 1) % NUM_REQ);
      end
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= '0;
    end else if (found && !hold) begin
      ptr <= ptr_nxt;
    end
  end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Shares one single-port sprite ROM between the layer fetchers: one grant per vga_clk,
// fixed-latency tagged responses returned in grant order.
module sprite_rom_arbiter
  import sprite_rom_pkg::*;
#(
  parameter bit PRIO0 = 1'b1
) (
  input  logic                      vga_clk,
  input  logic                      reset_n,
  input  req_vec_t                  req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output req_vec_t                  req_ready,
  output logic                      rom_en,
  output rom_addr_t                 rom_addr,
  input  logic [DATA_W-1:0]         rom_q,
  output req_vec_t                  rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      oor_err,
  output logic [15:0]               busy_cnt
);

  logic      prio_hit;
  req_vec_t  rr_gnt;
  logic      xfer;
  rom_addr_t sel_addr;
  logic      sel_oor;
  rom_tag_t  tag_q [ROM_LAT+1];

  // Background override leaves the round-robin pointer untouched.
  assign prio_hit = PRIO0 && req_valid[0];

  rr_arbiter u_rr (
    .vga_clk (vga_clk),
    .reset_n (reset_n),
    .req     (req_valid),
    .hold    (prio_hit),
    .gnt     (rr_gnt)
  );

  assign req_ready = prio_hit ? req_vec_t'(1) : rr_gnt;
  assign xfer      = |req_ready;

  always_comb begin
    sel_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) sel_addr |= req_addr[i*ADDR_W +: ADDR_W];
    end
  end

  assign sel_oor = addr_oor(sel_addr);

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      rom_en   <= 1'b0;
      rom_addr <= '0;
    end else begin
      rom_en <= xfer && !sel_oor;
      if (xfer) rom_addr <= sel_addr;
    end
  end

  // Stage 0 lines up with rom_en; the last stage lines up with valid rom_q.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k <= ROM_LAT; k++) tag_q[k] <= '0;
    end else begin
      tag_q[0] <= '{v: xfer, id: req_ready, oor: sel_oor};
      for (int k = 1; k <= ROM_LAT; k++) tag_q[k] <= tag_q[k-1];
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= tag_q[ROM_LAT].v ? tag_q[ROM_LAT].id : '0;
      rsp_data  <= (tag_q[ROM_LAT].v && !tag_q[ROM_LAT].oor) ? rom_q : '0;
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      oor_err  <= 1'b0;
      busy_cnt <= '0;
    end else begin
      if (xfer && sel_oor) oor_err <= 1'b1;
      if (xfer && busy_cnt != 16'hFFFF) busy_cnt <= busy_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Scoreboard bench: directed stimulus pushes expected responses, a negedge monitor pops
// and compares them. A second instance with the background override covers starvation.
module tb_sprite_rom_arbiter;
  import sprite_rom_pkg::*;

  logic                      vga_clk = 1'b0;
  logic                      reset_n;
  req_vec_t                  req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  req_vec_t                  req_ready;
  logic                      rom_en;
  rom_addr_t                 rom_addr;
  logic [DATA_W-1:0]         rom_q;
  req_vec_t                  rsp_valid;
  logic [DATA_W-1:0]         rsp_data;
  logic                      oor_err;
  logic [15:0]               busy_cnt;

  req_vec_t                  p_valid;
  logic [NUM_REQ*ADDR_W-1:0] p_addr;
  req_vec_t                  p_ready;
  logic                      p_rom_en;
  rom_addr_t                 p_rom_addr;
  logic [DATA_W-1:0]         p_rom_q;
  req_vec_t                  p_rsp_valid;
  logic [DATA_W-1:0]         p_rsp_data;
  logic                      p_oor_err;
  logic [15:0]               p_busy_cnt;

  typedef struct packed {
    req_vec_t          id;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 vga_clk = ~vga_clk;

  sprite_rom_arbiter #(.PRIO0(1'b0)) dut (
    .vga_clk(vga_clk), .reset_n(reset_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .rom_en(rom_en), .rom_addr(rom_addr), .rom_q(rom_q),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .oor_err(oor_err), .busy_cnt(busy_cnt)
  );

  sprite_rom_arbiter #(.PRIO0(1'b1)) dut_p0 (
    .vga_clk(vga_clk), .reset_n(reset_n), .req_valid(p_valid), .req_addr(p_addr),
    .req_ready(p_ready), .rom_en(p_rom_en), .rom_addr(p_rom_addr), .rom_q(p_rom_q),
    .rsp_valid(p_rsp_valid), .rsp_data(p_rsp_data), .oor_err(p_oor_err), .busy_cnt(p_busy_cnt)
  );

  assign p_rom_q = '0;

  // ROM model, two-cycle latency: data = addr[3:0]; 4'hA when no read was issued.
  rom_addr_t rp1_a, rp2_a;
  logic      rp1_v, rp2_v;
  always @(posedge vga_clk) begin
    rp1_v <= rom_en;
    rp1_a <= rom_addr;
    rp2_v <= rp1_v;
    rp2_a <= rp1_a;
  end
  assign rom_q = rp2_v ? rp2_a[3:0] : 4'hA;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic set_addr(input int i, input rom_addr_t a);
    req_addr[i*ADDR_W +: ADDR_W] = a;
  endtask

  always @(negedge vga_clk) begin
    if (rsp_valid != '0) begin
      if (sb.size() == 0) begin
        chk("rsp_unexpected", 32'(rsp_valid), 32'(0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_id", 32'(rsp_valid), 32'(e.id));
        chk("rsp_data", 32'(rsp_data), 32'(e.data));
      end
    end
  end

  task automatic apply_reset();
    req_valid = '0;
    p_valid   = '0;
    reset_n   = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
  endtask

  initial begin
    req_addr = '0;
    p_addr   = '0;
    apply_reset();

    // 1: reset values, single request latency
    chk("rst_ready", 32'(req_ready), 32'(0));
    chk("rst_rom_en", 32'(rom_en), 32'(0));
    chk("rst_rom_addr", 32'(rom_addr), 32'(0));
    chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("rst_rsp_data", 32'(rsp_data), 32'(0));
    chk("rst_oor_err", 32'(oor_err), 32'(0));
    chk("rst_busy_cnt", 32'(busy_cnt), 32'(0));
    set_addr(2, 19'h00100);
    req_valid = 4'b0100;
    #1 chk("t1_ready", 32'(req_ready), 32'(4'b0100));
    sb.push_back('{id: 4'b0100, data: 4'h0});
    tick();
    req_valid = '0;
    chk("t1_rom_en", 32'(rom_en), 32'(1));
    chk("t1_rom_addr", 32'(rom_addr), 32'(19'h00100));
    chk("t1_rsp_early0", 32'(rsp_valid), 32'(0));
    tick();
    chk("t1_rsp_early1", 32'(rsp_valid), 32'(0));
    chk("t1_rom_en_off", 32'(rom_en), 32'(0));
    chk("t1_rom_addr_hold", 32'(rom_addr), 32'(19'h00100));
    tick();
    chk("t1_rsp_early2", 32'(rsp_valid), 32'(0));
    tick();
    chk("t1_rsp_on_time", 32'(rsp_valid), 32'(4'b0100));
    repeat (3) tick();

    // 2: round-robin over all four for 8 grants
    apply_reset();
    for (int i = 0; i < NUM_REQ; i++) set_addr(i, rom_addr_t'(19'h002A0 | (i * 4 + 3)));
    req_valid = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      #1 chk("t2_rr_grant", 32'(req_ready), 32'(1 << (c % 4)));
      sb.push_back('{id: req_vec_t'(1 << (c % 4)), data: 4'((c % 4) * 4 + 3)});
      tick();
    end
    req_valid = '0;
    chk("t2_busy_cnt", 32'(busy_cnt), 32'(8));
    repeat (5) tick();

    // 4: back-to-back grants 1,3,1
    set_addr(1, 19'h00025);
    req_valid = 4'b0010;
    #1 chk("t4_g1", 32'(req_ready), 32'(4'b0010));
    sb.push_back('{id: 4'b0010, data: 4'h5});
    tick();
    set_addr(3, 19'h0003A);
    req_valid = 4'b1000;
    #1 chk("t4_g3", 32'(req_ready), 32'(4'b1000));
    sb.push_back('{id: 4'b1000, data: 4'hA});
    tick();
    set_addr(1, 19'h00047);
    req_valid = 4'b0010;
    #1 chk("t4_g1b", 32'(req_ready), 32'(4'b0010));
    sb.push_back('{id: 4'b0010, data: 4'h7});
    tick();
    req_valid = '0;
    tick();
    chk("t4_rsp0", 32'(rsp_valid), 32'(4'b0010));
    tick();
    chk("t4_rsp1", 32'(rsp_valid), 32'(4'b1000));
    tick();
    chk("t4_rsp2", 32'(rsp_valid), 32'(4'b0010));
    repeat (3) tick();

    // 5: last in-range address, then first out-of-range address
    set_addr(0, 19'h4AFFF);
    req_valid = 4'b0001;
    #1 chk("t5_ready_in", 32'(req_ready), 32'(4'b0001));
    sb.push_back('{id: 4'b0001, data: 4'hF});
    tick();
    chk("t5_rom_en_in", 32'(rom_en), 32'(1));
    chk("t5_oor_clear", 32'(oor_err), 32'(0));
    set_addr(0, 19'h4B000);
    #1 chk("t5_ready_oor", 32'(req_ready), 32'(4'b0001));
    sb.push_back('{id: 4'b0001, data: 4'h0});
    tick();
    req_valid = '0;
    chk("t5_rom_en_oor", 32'(rom_en), 32'(0));
    chk("t5_oor_set", 32'(oor_err), 32'(1));
    repeat (5) tick();
    chk("t5_oor_sticky", 32'(oor_err), 32'(1));
    chk("t5_busy_cnt", 32'(busy_cnt), 32'(13));

    // 3: background override starves requester 3 until it drops
    p_valid = 4'b1001;
    for (int c = 0; c < 5; c++) begin
      #1 chk("t3_prio0", 32'(p_ready), 32'(4'b0001));
      tick();
    end
    p_valid = 4'b1000;
    #1 chk("t3_req3_after", 32'(p_ready), 32'(4'b1000));
    tick();
    p_valid = '0;
    chk("t3_busy_cnt", 32'(p_busy_cnt), 32'(6));

    // 6: asynchronous reset with two reads in flight
    set_addr(2, 19'h00055);
    req_valid = 4'b0100;
    tick();
    set_addr(1, 19'h00066);
    req_valid = 4'b0010;
    #1 chk("t6_g1", 32'(req_ready), 32'(4'b0010));
    tick();
    req_valid = '0;
    #3 reset_n = 1'b0;
    #1;
    chk("t6_rst_rom_en", 32'(rom_en), 32'(0));
    chk("t6_rst_rom_addr", 32'(rom_addr), 32'(0));
    chk("t6_rst_oor", 32'(oor_err), 32'(0));
    chk("t6_rst_busy", 32'(busy_cnt), 32'(0));
    chk("t6_rst_rsp", 32'(rsp_valid), 32'(0));
    sb.delete();
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (5) tick();
    set_addr(1, 19'h0006C);
    set_addr(3, 19'h0007D);
    req_valid = 4'b1010;
    #1 chk("t6_ptr0_grant", 32'(req_ready), 32'(4'b0010));
    sb.push_back('{id: 4'b0010, data: 4'hC});
    tick();
    req_valid = '0;
    repeat (6) tick();
    chk("sb_drained", 32'(sb.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
